// File: rtl/sel_sequencer.sv
// Mode/selector sequencer: synchronizes and debounces two buttons, steps a 2-bit index
// (manually or by auto-scan) and presents it as binary (decode) or one-hot (encode).
module sel_sequencer #(
    parameter int DEB_CYCLES = 4,
    parameter int SCAN_DIV   = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_NEXT,
    input  logic       BTN_MODE,
    input  logic       AUTO,
    output logic       SW,
    output logic [3:0] Sel,
    output logic       CHG
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    // bit 0 = next button, bit 1 = mode button
    logic [1:0]         w_raw;
    logic [1:0]         r_sync1, r_sync2, r_lvl, r_lvl_q;
    logic [1:0][DW-1:0] r_dcnt;
    logic [1:0]         w_press;

    logic [PW-1:0]      r_pcnt;
    logic               w_tick, w_step, w_next_press, w_mode_press;

    logic [1:0]         r_idx, w_idx_n;
    logic               r_sw, w_sw_n;
    logic [3:0]         r_sel, w_sel_n;
    logic               r_chg, w_chg_n;

    assign w_raw = {BTN_MODE, BTN_NEXT};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl_q <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_lvl_q <= r_lvl;
        end
    end

    // Level is accepted only after it has differed for DEB_CYCLES consecutive edges
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lvl  <= '0;
            r_dcnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DW'(DEB_CYCLES - 1)) begin
                    r_lvl[i]  <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_press      = r_lvl & ~r_lvl_q;
    assign w_next_press = w_press[0];
    assign w_mode_press = w_press[1];

    assign w_tick = AUTO && (r_pcnt == PW'(SCAN_DIV - 1));
    assign w_step = w_next_press | w_tick;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_pcnt <= '0;
        else if (!AUTO || w_mode_press || w_tick)
            r_pcnt <= '0;
        else
            r_pcnt <= r_pcnt + PW'(1);
    end

    // Mode toggle takes priority over a coincident step
    always_comb begin
        w_idx_n = r_idx;
        w_sw_n  = r_sw;
        if (w_mode_press) begin
            w_sw_n  = ~r_sw;
            w_idx_n = 2'd0;
        end else if (w_step) begin
            w_idx_n = r_idx + 2'd1;
        end
        w_sel_n = w_sw_n ? (4'b0001 << w_idx_n) : {2'b00, w_idx_n};
        w_chg_n = w_mode_press | w_step;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx <= 2'd0;
            r_sw  <= 1'b0;
            r_sel <= 4'b0000;
            r_chg <= 1'b0;
        end else begin
            r_idx <= w_idx_n;
            r_sw  <= w_sw_n;
            r_sel <= w_sel_n;
            r_chg <= w_chg_n;
        end
    end

    assign SW  = r_sw;
    assign Sel = r_sel;
    assign CHG = r_chg;

endmodule
